bf2_bundle_pipe: RTL and testbench

//  Parametrised radix-2 SDF-style butterfly bundle for the FFT datapath.

---
 rtl/bf2_bundle_pipe.sv | 138 +++++++++++++
 tb/tb_bf2_bundle_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf2_bundle_pipe.sv
// bf2_bundle_pipe: radix-2 SDF butterfly bundle, DEPTH complex lanes per beat.
// Two register stages (operand prep, add/sub + optional 1/2 scaling) with
// valid/ready backpressure and a synchronous flush (clr).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr                 sync clear, drops in-flight beats (data regs kept)
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   mode                0 = BF2I, 1 = BF2II (-j on upper half of b lanes)
//   scale               1 = outputs are (x+1)>>>1
//   din_R/din_Q         DEPTH x WIDTH signed input components
//   out_valid/out_ready output handshake
//   dout_R/dout_Q       DEPTH x (WIDTH+1) signed results
module bf2_bundle_pipe #(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned OFFSET = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         mode,
    input  logic                         scale,
    input  logic [DEPTH-1:0][WIDTH-1:0]  din_R,
    input  logic [DEPTH-1:0][WIDTH-1:0]  din_Q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DEPTH-1:0][WIDTH:0]    dout_R,
    output logic [DEPTH-1:0][WIDTH:0]    dout_Q
);

    localparam int unsigned OW    = WIDTH + 1;
    localparam int unsigned SW    = WIDTH + 2;
    localparam int unsigned GRP   = 2 * OFFSET;
    localparam int unsigned NPAIR = DEPTH / 2;

    logic                      r_v1;
    logic                      r_v2;
    logic                      r_scale1;
    logic [DEPTH-1:0][OW-1:0]  r_s1_R;
    logic [DEPTH-1:0][OW-1:0]  r_s1_Q;
    logic [DEPTH-1:0][OW-1:0]  r_s2_R;
    logic [DEPTH-1:0][OW-1:0]  r_s2_Q;

    logic [DEPTH-1:0][OW-1:0]  w_s1_R;
    logic [DEPTH-1:0][OW-1:0]  w_s1_Q;
    logic [DEPTH-1:0][OW-1:0]  w_s2_R;
    logic [DEPTH-1:0][OW-1:0]  w_s2_Q;
    logic                      w_s1_adv;
    logic                      w_s2_adv;

    // Optional round-half-up halving; results always fit in WIDTH+1 bits.
    function automatic logic [OW-1:0] f_round(input logic signed [SW-1:0] x,
                                              input logic              sc);
        logic signed [SW-1:0] t;
        t = x + SW'(1);
        t = t >>> 1;
        return sc ? OW'(t) : OW'(x);
    endfunction

    // Handshake: a stage moves when its successor can take its beat.
    assign w_s2_adv  = !r_v2 || out_ready;
    assign w_s1_adv  = !r_v1 || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_v2;
    assign dout_R    = r_s2_R;
    assign dout_Q    = r_s2_Q;

    // Stage 1 operands: a lanes sign-extended, b lanes optionally rotated by -j.
    for (genvar l = 0; l < DEPTH; l++) begin : g_s1
        localparam int unsigned K   = l % GRP;
        localparam bit          ROT = (K >= OFFSET + OFFSET / 2);
        logic signed [OW-1:0] w_ext_R;
        logic signed [OW-1:0] w_ext_Q;
        assign w_ext_R = {din_R[l][WIDTH-1], din_R[l]};
        assign w_ext_Q = {din_Q[l][WIDTH-1], din_Q[l]};
        if (ROT) begin : g_rot
            // -j*(R + jQ) = Q - jR; negating -2^(WIDTH-1) fits in WIDTH+1 bits.
            assign w_s1_R[l] = mode ? w_ext_Q  : w_ext_R;
            assign w_s1_Q[l] = mode ? -w_ext_R : w_ext_Q;
        end else begin : g_pass
            assign w_s1_R[l] = w_ext_R;
            assign w_s1_Q[l] = w_ext_Q;
        end
    end

    // Stage 2 butterflies: sum into lane a, difference into lane b.
    for (genvar p = 0; p < NPAIR; p++) begin : g_s2
        localparam int unsigned LA = (p / OFFSET) * GRP + (p % OFFSET);
        localparam int unsigned LB = LA + OFFSET;
        logic signed [SW-1:0] w_a_R;
        logic signed [SW-1:0] w_a_Q;
        logic signed [SW-1:0] w_b_R;
        logic signed [SW-1:0] w_b_Q;
        assign w_a_R = SW'($signed(r_s1_R[LA]));
        assign w_a_Q = SW'($signed(r_s1_Q[LA]));
        assign w_b_R = SW'($signed(r_s1_R[LB]));
        assign w_b_Q = SW'($signed(r_s1_Q[LB]));
        assign w_s2_R[LA] = f_round(w_a_R + w_b_R, r_scale1);
        assign w_s2_Q[LA] = f_round(w_a_Q + w_b_Q, r_scale1);
        assign w_s2_R[LB] = f_round(w_a_R - w_b_R, r_scale1);
        assign w_s2_Q[LB] = f_round(w_a_Q - w_b_Q, r_scale1);
    end

    // Pipeline registers; clr only kills valids, bubbles keep stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_scale1 <= 1'b0;
            r_s1_R   <= '0;
            r_s1_Q   <= '0;
            r_s2_R   <= '0;
            r_s2_Q   <= '0;
        end else if (clr) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_v1 <= in_valid;
            end
            if (w_s2_adv) begin
                r_v2 <= r_v1;
            end
            if (w_s1_adv && in_valid) begin
                r_s1_R   <= w_s1_R;
                r_s1_Q   <= w_s1_Q;
                r_scale1 <= scale;
            end
            if (w_s2_adv && r_v1) begin
                r_s2_R <= w_s2_R;
                r_s2_Q <= w_s2_Q;
            end
        end
    end

endmodule

// File: tb/tb_bf2_bundle_pipe.sv
// Bench for bf2_bundle_pipe: behavioural butterfly model with an in-flight
// queue, a per-cycle compare process, directed literal cases and random traffic.
module tb_bf2_bundle_pipe;

    localparam int W  = 9;
    localparam int D  = 16;
    localparam int O  = 8;
    localparam int OW = W + 1;

    typedef logic [D-1:0][W-1:0]  din_t;
    typedef logic [D-1:0][OW-1:0] dout_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  clr = 1'b0;
    logic  in_valid = 1'b0;
    logic  in_ready;
    logic  mode = 1'b0;
    logic  scale = 1'b0;
    din_t  din_R = '0;
    din_t  din_Q = '0;
    logic  out_valid;
    logic  out_ready = 1'b1;
    dout_t dout_R;
    dout_t dout_Q;

    int checks = 0;
    int errors = 0;
    int nov_cnt = 0;
    dout_t exp_r_q[$];
    dout_t exp_q_q[$];

    bf2_bundle_pipe #(.WIDTH(W), .DEPTH(D), .OFFSET(O)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .scale(scale),
        .din_R(din_R), .din_Q(din_Q),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_R(dout_R), .dout_Q(dout_Q)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // floor((x+1)/2) with plain integer arithmetic
    function automatic int half_up(input int x);
        int t;
        t = x + 1;
        return (t >= 0) ? t / 2 : -((1 - t) / 2);
    endfunction

    // Butterfly result of one beat computed from the lane-pairing rules.
    function automatic void model(input din_t r, input din_t q, input logic m,
                                  input logic s, output dout_t er, output dout_t eq);
        int ar, aq, br, bq, tr, sr, sq, dr, dq;
        er = '0;
        eq = '0;
        for (int g = 0; g < D / (2 * O); g++) begin
            for (int k = 0; k < O; k++) begin
                int a, b;
                a  = g * 2 * O + k;
                b  = a + O;
                ar = $signed(r[a]); aq = $signed(q[a]);
                br = $signed(r[b]); bq = $signed(q[b]);
                if (m && k >= O / 2) begin
                    tr = br;
                    br = bq;
                    bq = -tr;
                end
                sr = ar + br; sq = aq + bq;
                dr = ar - br; dq = aq - bq;
                if (s) begin
                    sr = half_up(sr); sq = half_up(sq);
                    dr = half_up(dr); dq = half_up(dq);
                end
                er[a] = OW'(sr); eq[a] = OW'(sq);
                er[b] = OW'(dr); eq[b] = OW'(dq);
            end
        end
    endfunction

    // Compare process: handshakes take effect at the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                nov_cnt = 0;
                checks++;
                if (exp_r_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out: got out_valid=1 expected no beat in flight");
                end else if (dout_R !== exp_r_q[0] || dout_Q !== exp_q_q[0]) begin
                    errors++;
                    $display("FAIL dout_beat: got R=%h Q=%h expected R=%h Q=%h",
                             dout_R, dout_Q, exp_r_q[0], exp_q_q[0]);
                end
            end else if (exp_r_q.size() > 0) begin
                nov_cnt++;
                chk("beat_progress", int'(nov_cnt <= 1), 1);
            end else begin
                nov_cnt = 0;
            end
            chk("in_ready", int'(in_ready), int'(exp_r_q.size() < 2 || out_ready));
            if (clr) begin
                exp_r_q.delete();
                exp_q_q.delete();
            end else begin
                if (out_valid && out_ready && exp_r_q.size() > 0) begin
                    void'(exp_r_q.pop_front());
                    void'(exp_q_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    dout_t er, eq;
                    model(din_R, din_Q, mode, scale, er, eq);
                    exp_r_q.push_back(er);
                    exp_q_q.push_back(eq);
                end
            end
        end
    end

    // One beat into an empty pipe with out_ready high; checks 2-cycle latency.
    task automatic send_one(input din_t r, input din_t q, input logic m, input logic s);
        din_R = r; din_Q = q; mode = m; scale = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_cycle1_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_cycle2_out_valid", int'(out_valid), 1);
    endtask

    function automatic int lane(input dout_t v, input int i);
        return $signed(v[i]);
    endfunction

    task automatic rand_beat();
        for (int i = 0; i < D; i++) begin
            din_R[i] = W'($urandom_range(0, 511));
            din_Q[i] = W'($urandom_range(0, 511));
        end
    endtask

    initial begin
        din_t  vr, vq;
        dout_t snap_r;
        int    sent, cyc, wait_c;
        logic  acc;

        // reset state
        #23;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_dout_zero", int'(dout_R == '0 && dout_Q == '0), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // plain add/sub
        vr = '0; vq = '0;
        vr[0] = W'(100); vr[8] = W'(-50);
        send_one(vr, vq, 1'b0, 1'b0);
        chk("t1_R0", lane(dout_R, 0), 50);
        chk("t1_R8", lane(dout_R, 8), 150);
        chk("t1_R1", lane(dout_R, 1), 0);

        // extremes
        vr = '0; vr[0] = W'(255); vr[8] = W'(255);
        send_one(vr, vq, 1'b0, 1'b0);
        chk("t2a_R0", lane(dout_R, 0), 510);
        chk("t2a_R8", lane(dout_R, 8), 0);
        vr[0] = W'(-256);
        send_one(vr, vq, 1'b0, 1'b0);
        chk("t2b_R0", lane(dout_R, 0), -1);
        chk("t2b_R8", lane(dout_R, 8), -511);

        // -j rotation only on the upper half of b lanes
        vr = '0; vq = '0;
        vr[12] = W'(10); vq[12] = W'(3);
        vr[11] = W'(10); vq[11] = W'(3);
        send_one(vr, vq, 1'b1, 1'b0);
        chk("t3_R4", lane(dout_R, 4), 3);
        chk("t3_Q4", lane(dout_Q, 4), -10);
        chk("t3_R12", lane(dout_R, 12), -3);
        chk("t3_Q12", lane(dout_Q, 12), 10);
        chk("t3_R3", lane(dout_R, 3), 10);
        chk("t3_Q3", lane(dout_Q, 3), 3);
        chk("t3_R11", lane(dout_R, 11), -10);
        chk("t3_Q11", lane(dout_Q, 11), -3);

        // scaling with round-half-up
        vr = '0; vq = '0;
        vr[0] = W'(3);
        send_one(vr, vq, 1'b0, 1'b1);
        chk("t4a_R0", lane(dout_R, 0), 2);
        chk("t4a_R8", lane(dout_R, 8), 2);
        vr[0] = W'(-3);
        send_one(vr, vq, 1'b0, 1'b1);
        chk("t4b_R0", lane(dout_R, 0), -1);
        vr[0] = W'(255); vr[8] = W'(255);
        send_one(vr, vq, 1'b0, 1'b1);
        chk("t4c_R0", lane(dout_R, 0), 255);

        // six-beat stream with a stall window, mode/scale toggling per beat
        sent = 0; cyc = 0; acc = 1'b1; snap_r = '0;
        while (sent < 6 && cyc < 40) begin
            if (acc) begin
                rand_beat();
                mode = sent[0];
                scale = sent[1];
            end
            in_valid = 1'b1;
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (cyc == 3) snap_r = dout_R;
            if (cyc >= 4 && cyc <= 6) begin
                chk("t5_stall_in_ready", int'(in_ready), 0);
                chk("t5_stall_dout_frozen", int'(dout_R == snap_r), 1);
            end
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("t5_all_sent", sent, 6);
        wait_c = 0;
        while (exp_r_q.size() > 0 && wait_c < 20) begin
            @(posedge clk); #1;
            wait_c++;
        end
        chk("t5_drained", exp_r_q.size(), 0);

        // clr with both stages full and a beat offered
        out_ready = 1'b0;
        rand_beat(); in_valid = 1'b1;
        @(posedge clk); #1;
        rand_beat();
        @(posedge clk); #1;
        chk("t6_full_in_ready", int'(in_ready), 0);
        clr = 1'b1; rand_beat(); out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("t6_clr_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("t6_clr_no_ghost", int'(out_valid), 0);
        vr = '0; vq = '0;
        vr[0] = W'(100); vr[8] = W'(-50);
        send_one(vr, vq, 1'b0, 1'b0);
        chk("t6_after_R0", lane(dout_R, 0), 50);
        chk("t6_after_R8", lane(dout_R, 8), 150);

        // random traffic with occasional clr
        for (int c = 0; c < 800; c++) begin
            rand_beat();
            mode = 1'($urandom_range(0, 1));
            scale = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        clr = 1'b0;

        // async reset mid-stream
        out_ready = 1'b0;
        rand_beat(); in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_pre_rst_out_valid", int'(out_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_dout_zero", int'(dout_R == '0 && dout_Q == '0), 1);
        exp_r_q.delete();
        exp_q_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vr = '0; vq = '0;
        vr[0] = W'(3);
        send_one(vr, vq, 1'b0, 1'b1);
        chk("t6_post_rst_R0", lane(dout_R, 0), 2);

        // final drain
        wait_c = 0;
        while (exp_r_q.size() > 0 && wait_c < 20) begin
            @(posedge clk); #1;
            wait_c++;
        end
        chk("final_drained", exp_r_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
